// File: rtl/fifo_pkg.sv
// Shared width helpers and parameter-legality check for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full buffer.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned ADDR_W = addr_w(DEF_DEPTH);
    localparam int unsigned CNT_W  = cnt_w(DEF_DEPTH);

    function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                     input int unsigned af_level, input int unsigned ae_level);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0)
            && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle of the synchronous FIFO; the FIFO takes the slave view.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);

    logic                       flush;
    logic                       wr;
    logic [WIDTH-1:0]           data_in;
    logic                       rd;
    logic [WIDTH-1:0]           data_out;
    logic                       data_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [cnt_w(DEPTH)-1:0]    count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output flush, wr, data_in, rd,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr, data_in, rd,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_wr_en,
    input  logic [addr_w(DEPTH)-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic [addr_w(DEPTH)-1:0]   i_rd_addr,
    output logic [WIDTH-1:0]           o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A same-edge write to the read address returns the old entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, level flags and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    sync_fifo_param_if.slave   bus
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A read frees a slot, so a full buffer still takes a write alongside it.
    assign w_rd_ok = bus.rd && !w_empty && !bus.flush;
    assign w_wr_ok = bus.wr && (!w_full || bus.rd) && !bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_data_valid <= w_rd_ok;
            if (bus.rd && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (bus.wr && w_full && !bus.rd) begin
                r_overflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Level flags decode the count register only.
    assign bus.data_out     = w_rd_data;
    assign bus.data_valid   = r_data_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16).
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected level flags derived from an expected occupancy.
    task automatic chk_level(input string tag, input logic [CNT_W-1:0] n);
        chk({tag, ".count"}, 32'(bus.count), 32'(n));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, ".full"},  32'(bus.full),  32'(n == DEPTH));
        chk({tag, ".af"},    32'(bus.almost_full),  32'(n >= AF));
        chk({tag, ".ae"},    32'(bus.almost_empty), 32'(n <= AE));
    endtask

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic f);
        bus.wr = w; bus.data_in = d; bus.rd = r; bus.flush = f;
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.data_in = '0;
        #12;
        chk_level("reset", 0);
        chk("reset.dout", 32'(bus.data_out), 0);
        chk("reset.dv",   32'(bus.data_valid), 0);
        chk("reset.ovf",  32'(bus.overflow), 0);
        chk("reset.unf",  32'(bus.underflow), 0);
        #6 reset_n = 1'b1;

        // Read from empty: sticky underflow, no data
        cyc(0, 8'h00, 1, 0);
        chk("rd_empty.unf",  32'(bus.underflow), 1);
        chk("rd_empty.dv",   32'(bus.data_valid), 0);
        chk("rd_empty.dout", 32'(bus.data_out), 0);
        chk_level("rd_empty", 0);
        cyc(0, 8'h00, 0, 0);
        chk("unf_hold", 32'(bus.underflow), 1);
        cyc(0, 8'h00, 0, 1);
        chk("unf_flush", 32'(bus.underflow), 0);

        // Fill to full
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk_level($sformatf("fill%0d", i), 5'(i));
        end
        chk("fill.dv", 32'(bus.data_valid), 0);

        // Full with simultaneous read and write
        cyc(1, 8'h55, 1, 0);
        chk("full_rw.dout", 32'(bus.data_out), 32'h01);
        chk("full_rw.dv",   32'(bus.data_valid), 1);
        chk("full_rw.ovf",  32'(bus.overflow), 0);
        chk_level("full_rw", 16);

        // Dropped write while full
        cyc(1, 8'hAA, 0, 0);
        chk("ovf.set",  32'(bus.overflow), 1);
        chk("ovf.dv",   32'(bus.data_valid), 0);
        chk("ovf.dout", 32'(bus.data_out), 32'h01);
        chk_level("ovf", 16);

        // Drain: 0x02..0x10 then 0x55, never 0xAA
        for (int k = 0; k < 16; k++) begin
            cyc(0, 8'h00, 1, 0);
            chk($sformatf("drain%0d.dout", k), 32'(bus.data_out), (k < 15) ? 32'(k + 2) : 32'h55);
            chk($sformatf("drain%0d.dv", k), 32'(bus.data_valid), 1);
            chk_level($sformatf("drain%0d", k), 5'(15 - k));
        end
        cyc(0, 8'h00, 0, 0);
        chk("idle.dv",   32'(bus.data_valid), 0);
        chk("idle.dout", 32'(bus.data_out), 32'h55);
        chk("idle.ovf",  32'(bus.overflow), 1);
        cyc(0, 8'h00, 0, 1);
        chk("flush.ovf", 32'(bus.overflow), 0);
        chk("flush.unf", 32'(bus.underflow), 0);
        chk("flush.dout_hold", 32'(bus.data_out), 32'h55);

        // Streaming with pointer wrap
        cyc(1, 8'h00, 0, 0);
        chk_level("stream0", 1);
        for (int k = 1; k <= 2 * (1 << ADDR_W) + 8; k++) begin
            cyc(1, 8'(k), 1, 0);
            chk($sformatf("stream%0d.dout", k), 32'(bus.data_out), 32'(k - 1));
            chk($sformatf("stream%0d.dv", k), 32'(bus.data_valid), 1);
            chk($sformatf("stream%0d.count", k), 32'(bus.count), 1);
        end
        cyc(0, 8'h00, 1, 0);
        chk("stream_end.dout", 32'(bus.data_out), 32'd40);
        chk_level("stream_end", 0);

        // Flush with five entries and a concurrent write
        cyc(0, 8'h00, 1, 0);
        chk("pre_flush.unf", 32'(bus.underflow), 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hB0 + i), 0, 0);
        chk_level("five", 5);
        cyc(1, 8'hCC, 0, 1);
        chk_level("flush_wr", 0);
        chk("flush_wr.unf",  32'(bus.underflow), 0);
        chk("flush_wr.ovf",  32'(bus.overflow), 0);
        chk("flush_wr.dv",   32'(bus.data_valid), 0);
        chk("flush_wr.dout", 32'(bus.data_out), 32'd40);
        cyc(1, 8'h3C, 0, 0);
        chk_level("post_flush_wr", 1);
        cyc(0, 8'h00, 1, 0);
        chk("post_flush_rd.dout", 32'(bus.data_out), 32'h3C);

        // Asynchronous reset in the middle of a burst
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 1, 0);
        chk("burst.dout", 32'(bus.data_out), 32'h11);
        chk("burst.dv",   32'(bus.data_valid), 1);
        chk_level("burst", 2);
        bus.wr = 1'b1; bus.data_in = 8'h44;
        #2 reset_n = 1'b0;
        #1;
        chk_level("async_rst", 0);
        chk("async_rst.dout", 32'(bus.data_out), 0);
        chk("async_rst.dv",   32'(bus.data_valid), 0);
        #2 reset_n = 1'b1;
        bus.wr = 1'b0;
        cyc(1, 8'h77, 0, 0);
        chk_level("post_rst_wr", 1);
        cyc(0, 8'h00, 1, 0);
        chk("post_rst_rd.dout", 32'(bus.data_out), 32'h77);
        chk("post_rst_rd.dv",   32'(bus.data_valid), 1);

        // Empty with read and write together: write wins, read rejected
        cyc(1, 8'h99, 1, 0);
        chk_level("empty_rw", 1);
        chk("empty_rw.unf", 32'(bus.underflow), 1);
        chk("empty_rw.dv",  32'(bus.data_valid), 0);
        cyc(0, 8'h00, 1, 0);
        chk("empty_rw_rd.dout", 32'(bus.data_out), 32'h99);
        chk_level("empty_rw_rd", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next-generation single-clock buffer, generalised in data width and depth. Adds a fill-level count, programmable almost-full/almost-empty flags, a synchronous flush, a read-data valid strobe, and sticky overflow/underflow error flags. It sits between any producer and consumer sharing `clk`, replacing the fixed 8x8 FIFO in new designs.

## Interface
- `WIDTH`, 8, data element width in bits (>= 1)
- `DEPTH`, 16, element count; power of two, >= 4
- `AF_LEVEL`, DEPTH-2, `almost_full` asserts when count >= AF_LEVEL
- `AE_LEVEL`, 2, `almost_empty` asserts when count <= AE_LEVEL
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of contents and error flags
- `wr`  in  1  write request
- `data_in`  in  WIDTH  write data
- `rd`  in  1  read request
- `data_out`  out  WIDTH  registered read data
- `data_valid`  out  1  one-cycle strobe: `data_out` updated this cycle
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= AF_LEVEL
- `almost_empty`  out  1  count <= AE_LEVEL
- `count`  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH
- `overflow`  out  1  sticky: a write was dropped
- `underflow`  out  1  sticky: a read was rejected

## Operation
- Reset (`reset_n`=0, asynchronous): read/write pointers 0, count 0, `data_out` 0, `data_valid` 0, `overflow`/`underflow` 0. This gives `empty`=1, `full`=0, `almost_empty`=1, and `almost_full`=0 (for AF_LEVEL >= 1). Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is the occupancy register: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
- Read accept: `rd_ok = rd && !empty`.
- Write accept: `wr_ok = wr && (!full || rd)`. When full, a simultaneous read frees a slot, so both are accepted and count stays DEPTH.
- Empty with `rd` and `wr` together: the write is accepted and the read is rejected (no fall-through). `underflow` is set and count becomes 1.
- `rd` while empty sets `underflow`. `wr` while full without `rd` sets `overflow` and leaves memory untouched. Both flags hold until `flush` or reset.
- `flush` has priority over `wr`/`rd` in the same cycle. It zeroes pointers, count and both error flags. `data_out` holds its value and `data_valid` is 0.
- `full`, `empty`, `almost_full` and `almost_empty` are decoded from the count register only, with no combinational path from `wr`/`rd`.

## Timing
- Write latency: data written at edge N is readable by `rd` asserted in cycle N+1 (`empty` falls after edge N).
- Read latency 1: `rd_ok` sampled at edge N gives `data_out` and `data_valid`=1 after edge N. `data_valid` lasts one cycle per accepted read. `data_out` holds between reads.
- Back-to-back reads and writes at full rate: one element per cycle in each direction.
- Flags and `count` update on the same edge as the accepted operation.
- Reset mid-operation: all outputs take reset values immediately (asynchronously); first accepted write is allowed on the first edge after `reset_n` rises.

## Structure
- Package `fifo_pkg`: the `clog2`-based width constants (`ADDR_W`, `CNT_W`), plus a parameter-legality check that DEPTH is a power of two, DEPTH >= 4, and AE_LEVEL < AF_LEVEL <= DEPTH.
- Sub-module `fifo_mem`: a simple dual-port register array (WIDTH x DEPTH) with a synchronous write and a registered read. The top level holds pointers, count, flags and accept logic.

## Test plan
- Reset, then write 0x01..0x10 with DEPTH=16 -> `full`=1, `count`=16, `almost_full` from count 14; the 17th write (0xAA) sets `overflow`, and the following reads return 0x01..0x10 with no 0xAA.
- Read from empty after reset -> `underflow`=1, `data_valid`=0, `data_out`=0x00; `underflow` stays 1 until `flush`.
- Full with `rd`+`wr`(0x55) in one cycle -> `data_out`=oldest entry, `count` stays 16, `overflow`=0; 0x55 later emerges as the last element.
- Continuous write/read for 40 cycles (pointer wraps twice) with incrementing data -> output sequence is identical and one cycle behind; `count` stays 1.
- `flush` asserted while holding 5 entries, with `wr`=1 in the same cycle -> `count`=0, `empty`=1, error flags cleared, the write is dropped, and `data_out` is unchanged.
- Assert `reset_n`=0 mid-burst between edges -> outputs go to reset values before the next edge; a write of 0x77 after release reads back 0x77.
